// File: rtl/huff_pkg.sv
// Shared constants for the serial Huffman/run-length coefficient decoder:
// FSM state encoding, per-state field lengths and block geometry.
package huff_pkg;

    // FSM states, kept as plain constants so older tools can consume them.
    localparam logic [1:0] ST_PREFIX = 2'd0;
    localparam logic [1:0] ST_SHORT  = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_ESC    = 2'd3;

    // Number of field bits following each prefix.
    localparam logic [3:0] SHORT_LEN = 4'd3;   // s mm
    localparam logic [3:0] RUN_LEN   = 4'd3;   // rr s
    localparam logic [3:0] ESC_LEN   = 4'd14;  // rrrr vvvvvvvvvv

    localparam int         BLOCK_SIZE    = 16;
    // last_pos value meaning "no coefficient emitted yet in this block" (-1).
    localparam logic [4:0] LAST_POS_NONE = 5'h1F;

endpackage

// File: rtl/huff_field_shift.sv
// Field collector for the decoder: a shift register plus a down-counter of
// remaining bits. 'load' arms it with a field length; 'done' flags the
// accepted bit that completes the field, with field_next already holding it.
module huff_field_shift
    import huff_pkg::*;
#(
    parameter int FIELD_W = int'(ESC_LEN),
    parameter int CNT_W   = 4
) (
    input  logic               phi1,
    input  logic               reset_n,
    input  logic               load,
    input  logic [CNT_W-1:0]   load_len,
    input  logic               shift_en,
    input  logic               bit_in,
    output logic [FIELD_W-1:0] field_next,
    output logic               done
);

    logic [FIELD_W-2:0] field_q, field_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // The incoming bit is appended combinationally so the completing bit is
    // visible to the decoder in the same cycle it is accepted.
    assign field_next = {field_q, bit_in};
    assign done       = shift_en && (count_q == CNT_W'(1));

    // Next-state: arm on load, shift and count down on each accepted bit.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        field_d = field_q;
        count_d = count_q;
        if (load) begin
            field_d = '0;
            count_d = load_len;
        end else if (shift_en) begin
            field_d = field_next[FIELD_W-2:0];
            count_d = count_q - CNT_W'(1);
        end
    end

    // Field and counter registers.
    always_ff @(posedge phi1 or negedge reset_n) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (!reset_n) begin
            field_q <= '0;
            count_q <= '0;
        end else begin
            field_q <= field_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/huff_decoder.sv
// Serial Huffman/run-length decoder for 4x4 coefficient blocks. Consumes one
// stream bit per cycle and emits a registered coefficient/position beat one
// cycle after each symbol completes. stall_s2 freezes the whole decoder.
// Optional feature: define HUFF_DEC_ERR_CNT_EN to build the saturating
// position-overflow counter on err_count; otherwise err_count is tied to 0.
module huff_decoder
    import huff_pkg::*;
#(
    parameter int COEF_W = 10,
    parameter int POS_W  = 4
) (
    input  logic              phi1,
    input  logic              reset_n,
    input  logic              bit_in_s1,
    input  logic              bit_valid_s1,
    output logic              bit_ready_s1,
    input  logic              stall_s2,
    output logic [COEF_W-1:0] coefficient_s2,
    output logic [POS_W-1:0]  position_s2,
    output logic              valid_s2,
    output logic              new_block_s2,
    output logic              error_s2,
    output logic [7:0]        err_count
);

    logic [1:0]        state_q, state_d;
    logic [1:0]        ones_q, ones_d;        // leading 1s seen in the prefix
    logic              block_open_q, block_open_d;
    logic [4:0]        last_pos_q, last_pos_d;
    logic [COEF_W-1:0] coefficient_q, coefficient_d;
    logic [POS_W-1:0]  position_q, position_d;
    logic              valid_q, valid_d;
    logic              new_block_q, new_block_d;
    logic              error_q, error_d;

    logic              accept;
    logic              fld_load, fld_shift, fld_done;
    logic [3:0]        fld_len;
    logic [13:0]       fld_next;
    logic              sym_done, sym_eob;
    logic [3:0]        sym_run;
    logic [COEF_W-1:0] sym_coef, mag;
    logic [4:0]        pos;

    assign bit_ready_s1 = !stall_s2;
    assign accept       = bit_valid_s1 && !stall_s2;
    assign fld_shift    = accept && (state_q != ST_PREFIX);

    huff_field_shift #(
        .FIELD_W (int'(ESC_LEN)),
        .CNT_W   (4)
    ) u_field (
        .phi1       (phi1),
        .reset_n    (reset_n),
        .load       (fld_load),
        .load_len   (fld_len),
        .shift_en   (fld_shift),
        .bit_in     (bit_in_s1),
        .field_next (fld_next),
        .done       (fld_done)
    );

    // Prefix decode, symbol assembly and block/position bookkeeping.
    always_comb begin
        state_d       = state_q;
        ones_d        = ones_q;
        block_open_d  = block_open_q;
        last_pos_d    = last_pos_q;
        coefficient_d = coefficient_q;
        position_d    = position_q;
        valid_d       = valid_q;
        new_block_d   = new_block_q;
        error_d       = error_q;
        fld_load      = 1'b0;
        fld_len       = '0;
        sym_done      = 1'b0;
        sym_eob       = 1'b0;
        sym_run       = '0;
        sym_coef      = '0;
        mag           = '0;
        pos           = '0;

        if (!stall_s2) begin
            // Pulses last one cycle unless held by a stall.
            valid_d     = 1'b0;
            new_block_d = 1'b0;
            error_d     = 1'b0;

            if (accept) begin
                case (state_q)
                    ST_PREFIX: begin
                        if (ones_q == 2'd0) begin
                            if (bit_in_s1) ones_d = 2'd1;
                            else           sym_eob = 1'b1;
                        end else if (ones_q == 2'd1) begin
                            if (bit_in_s1) begin
                                ones_d = 2'd2;
                            end else begin
                                ones_d   = 2'd0;
                                state_d  = ST_SHORT;
                                fld_load = 1'b1;
                                fld_len  = SHORT_LEN;
                            end
                        end else begin
                            ones_d   = 2'd0;
                            fld_load = 1'b1;
                            state_d  = bit_in_s1 ? ST_ESC : ST_RUN;
                            fld_len  = bit_in_s1 ? ESC_LEN : RUN_LEN;
                        end
                    end
                    ST_SHORT: begin
                        // s mm: level mm+1, sign s, run 0.
                        mag      = COEF_W'(fld_next[1:0]) + COEF_W'(1);
                        sym_coef = fld_next[2] ? -mag : mag;
                        sym_done = fld_done;
                    end
                    ST_RUN: begin
                        // rr s: level +-1 after rr zeros.
                        mag      = COEF_W'(1);
                        sym_coef = fld_next[0] ? -mag : mag;
                        sym_run  = {2'b00, fld_next[2:1]};
                        sym_done = fld_done;
                    end
                    default: begin
                        // rrrr v: raw two's-complement value after rrrr zeros.
                        sym_coef = COEF_W'($signed(fld_next[9:0]));
                        sym_run  = fld_next[13:10];
                        sym_done = fld_done;
                    end
                endcase
                if (sym_done) state_d = ST_PREFIX;
            end

            // last_pos is -1 (all ones) at block start, so 5-bit wraparound
            // gives run for the first symbol; bit 4 flags a position past 15.
            pos = last_pos_q + {1'b0, sym_run} + 5'd1;

            if (sym_eob) begin
                new_block_d  = !block_open_q;
                block_open_d = 1'b0;
                last_pos_d   = LAST_POS_NONE;
            end else if (sym_done) begin
                new_block_d = !block_open_q;
                if (!pos[4]) begin
                    valid_d       = 1'b1;
                    coefficient_d = sym_coef;
                    position_d    = POS_W'(pos[3:0]);
                    if (pos[3:0] == 4'(BLOCK_SIZE - 1)) begin
                        block_open_d = 1'b0;
                        last_pos_d   = LAST_POS_NONE;
                    end else begin
                        block_open_d = 1'b1;
                        last_pos_d   = pos;
                    end
                end else begin
                    error_d      = 1'b1;
                    block_open_d = 1'b0;
                    last_pos_d   = LAST_POS_NONE;
                end
            end
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_PREFIX;
            ones_q        <= 2'd0;
            block_open_q  <= 1'b0;
            last_pos_q    <= LAST_POS_NONE;
            coefficient_q <= '0;
            position_q    <= '0;
            valid_q       <= 1'b0;
            new_block_q   <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ones_q        <= ones_d;
            block_open_q  <= block_open_d;
            last_pos_q    <= last_pos_d;
            coefficient_q <= coefficient_d;
            position_q    <= position_d;
            valid_q       <= valid_d;
            new_block_q   <= new_block_d;
            error_q       <= error_d;
        end
    end

    assign coefficient_s2 = coefficient_q;
    assign position_s2    = position_q;
    assign valid_s2       = valid_q;
    assign new_block_s2   = new_block_q;
    assign error_s2       = error_q;

`ifdef HUFF_DEC_ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Saturating count of position-overflow errors, stepped with error_s2.
    always_comb begin
        err_count_d = err_count_q;
        if (error_d && !error_q && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        else if (error_d && !stall_s2 && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    // Error counter register.
    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) err_count_q <= 8'd0;
        else          err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_huff_decoder.sv
// Self-checking bench for huff_decoder: directed scenarios plus randomized
// symbol streams compared against a position/block model written in plain
// integer arithmetic.
module tb_huff_decoder;

    typedef struct packed {
        logic       valid;
        logic       nb;
        logic       err;
        logic [9:0] coef;
        logic [3:0] pos;
    } ev_t;

    logic       phi1 = 1'b0;
    logic       reset_n = 1'b0;
    logic       bit_in_s1 = 1'b0;
    logic       bit_valid_s1 = 1'b0;
    logic       stall_s2 = 1'b0;
    logic       bit_ready_s1;
    logic [9:0] coefficient_s2;
    logic [3:0] position_s2;
    logic       valid_s2;
    logic       new_block_s2;
    logic       error_s2;
    logic [7:0] err_count;

    int  n_checks = 0;
    int  n_pass   = 0;
    bit  stim_q[$];
    ev_t exp_q[$];
    ev_t obs_q[$];
    int  m_last;
    bit  m_open;
    int  m_errs;

    huff_decoder #(.COEF_W(10), .POS_W(4)) dut (
        .phi1           (phi1),
        .reset_n        (reset_n),
        .bit_in_s1      (bit_in_s1),
        .bit_valid_s1   (bit_valid_s1),
        .bit_ready_s1   (bit_ready_s1),
        .stall_s2       (stall_s2),
        .coefficient_s2 (coefficient_s2),
        .position_s2    (position_s2),
        .valid_s2       (valid_s2),
        .new_block_s2   (new_block_s2),
        .error_s2       (error_s2),
        .err_count      (err_count)
    );

    always #5 phi1 = ~phi1;

    function automatic ev_t mk_ev(bit v, bit nb, bit err, logic [9:0] coef, logic [3:0] pos);
        ev_t e;
        e.valid = v; e.nb = nb; e.err = err;
        e.coef = v ? coef : 10'd0;
        e.pos  = v ? pos : 4'd0;
        return e;
    endfunction

    function automatic string ev_str(ev_t e);
        return $sformatf("v=%0b nb=%0b err=%0b coef=%0d pos=%0d",
                         e.valid, e.nb, e.err, $signed(e.coef), e.pos);
    endfunction

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_last = -1; m_open = 1'b0; m_errs = 0;
    endtask

    task automatic model_symbol(input int run, input logic [9:0] coef);
        int p;
        p = m_last + run + 1;
        if (p <= 15) begin
            exp_q.push_back(mk_ev(1'b1, !m_open, 1'b0, coef, 4'(p)));
            m_open = 1'b1;
            m_last = p;
            if (p == 15) begin m_open = 1'b0; m_last = -1; end
        end else begin
            exp_q.push_back(mk_ev(1'b0, !m_open, 1'b1, 10'd0, 4'd0));
            m_open = 1'b0;
            m_last = -1;
`ifdef HUFF_DEC_ERR_CNT_EN
            if (m_errs < 255) m_errs++;
`endif
        end
    endtask

    task automatic model_eob();
        if (!m_open) exp_q.push_back(mk_ev(1'b0, 1'b1, 1'b0, 10'd0, 4'd0));
        m_open = 1'b0;
        m_last = -1;
    endtask

    // ---------------- encoders ----------------
    task automatic put_bits(input logic [17:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stim_q.push_back(v[i]);
    endtask

    task automatic sym_eob();
        put_bits(18'd0, 1);
        model_eob();
    endtask

    task automatic sym_short(input bit s, input logic [1:0] mm);
        int lvl;
        put_bits({13'd0, 2'b10, s, mm}, 5);
        lvl = int'(mm) + 1;
        model_symbol(0, s ? 10'(-lvl) : 10'(lvl));
    endtask

    task automatic sym_run(input logic [1:0] rr, input bit s);
        put_bits({12'd0, 3'b110, rr, s}, 6);
        model_symbol(int'(rr), s ? 10'(-1) : 10'(1));
    endtask

    task automatic sym_esc(input logic [3:0] r, input logic [9:0] v);
        put_bits({1'b0, 3'b111, r, v}, 17);
        model_symbol(int'(r), v);
    endtask

    // ---------------- driver / monitor ----------------
    task automatic sample_outputs();
        if (valid_s2 || new_block_s2 || error_s2)
            obs_q.push_back(mk_ev(valid_s2, new_block_s2, error_s2, coefficient_s2, position_s2));
    endtask

    task automatic run_stream(input int gap_pct);
        while (stim_q.size() > 0) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                bit_valid_s1 = 1'b0;
                bit_in_s1    = 1'($urandom_range(0, 1));
            end else begin
                bit_valid_s1 = 1'b1;
                bit_in_s1    = stim_q[0];
            end
            @(posedge phi1);
            if (bit_valid_s1) void'(stim_q.pop_front());
            #1;
            sample_outputs();
        end
        bit_valid_s1 = 1'b0;
        repeat (2) begin
            @(posedge phi1); #1;
            sample_outputs();
        end
    endtask

    task automatic drive_bits(input logic [17:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bit_valid_s1 = 1'b1;
            bit_in_s1    = v[i];
            @(posedge phi1); #1;
        end
        bit_valid_s1 = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; bit_valid_s1 = 1'b0; stall_s2 = 1'b0;
        repeat (2) @(posedge phi1);
        #1 reset_n = 1'b1;
        model_reset();
        stim_q.delete(); exp_q.delete(); obs_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({coefficient_s2, position_s2, valid_s2, new_block_s2, error_s2, err_count} !== 27'd0)
            $display("FAIL reset_outputs: got coef=%0h pos=%0h v=%0b nb=%0b err=%0b cnt=%0d, required all 0",
                     coefficient_s2, position_s2, valid_s2, new_block_s2, error_s2, err_count);
        else n_pass++;
        n_checks++;
        if (bit_ready_s1 !== 1'b1) $display("FAIL reset_ready: got %b, required 1", bit_ready_s1);
        else n_pass++;
    endtask

    task automatic test_plan();
        ev_t req[$];
        apply_reset();
        put_bits(18'b10001, 5);
        put_bits(18'b110101, 6);
        put_bits(18'b0, 1);
        put_bits(18'b0, 1);
        put_bits({1'b0, 3'b111, 4'b0000, 10'b1000000000}, 17);
        put_bits({1'b0, 3'b111, 4'b1111, 10'b0000000001}, 17);
        for (int i = 0; i < 17; i++) put_bits(18'b10000, 5);
        run_stream(0);

        req.push_back(mk_ev(1, 1, 0, 10'd2, 4'd0));
        req.push_back(mk_ev(1, 0, 0, 10'h3FF, 4'd3));
        req.push_back(mk_ev(0, 1, 0, 10'd0, 4'd0));
        req.push_back(mk_ev(1, 1, 0, 10'h200, 4'd0));
        req.push_back(mk_ev(0, 0, 1, 10'd0, 4'd0));
        for (int i = 0; i < 16; i++) req.push_back(mk_ev(1, (i == 0), 0, 10'd1, 4'(i)));
        req.push_back(mk_ev(1, 1, 0, 10'd1, 4'd0));

        n_checks++;
        if (obs_q.size() != req.size())
            $display("FAIL plan_count: got %0d beats, required %0d", obs_q.size(), req.size());
        else n_pass++;
        for (int i = 0; i < req.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size())
                $display("FAIL plan_beat[%0d]: got none, required %s", i, ev_str(req[i]));
            else if (obs_q[i] !== req[i])
                $display("FAIL plan_beat[%0d]: got %s, required %s", i, ev_str(obs_q[i]), ev_str(req[i]));
            else n_pass++;
        end
        n_checks++;
`ifdef HUFF_DEC_ERR_CNT_EN
        if (err_count !== 8'd1) $display("FAIL plan_err_count: got %0d, required 1", err_count);
`else
        if (err_count !== 8'd0) $display("FAIL plan_err_count: got %0d, required 0", err_count);
`endif
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 5; i++) sym_eob();
        sym_short(1'b0, 2'd3);
        sym_eob();
        sym_eob();
        run_stream(0);
        n_checks++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL b2b_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size())
                $display("FAIL b2b_beat[%0d]: got none, required %s", i, ev_str(exp_q[i]));
            else if (obs_q[i] !== exp_q[i])
                $display("FAIL b2b_beat[%0d]: got %s, required %s", i, ev_str(obs_q[i]), ev_str(exp_q[i]));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int k;
        apply_reset();
        for (int round = 0; round < 3; round++) begin
            exp_q.delete(); obs_q.delete();
            for (int s = 0; s < 40; s++) begin
                k = $urandom_range(0, 9);
                if (k < 2)      sym_eob();
                else if (k < 5) sym_short(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                else if (k < 8) sym_run(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                else            sym_esc(4'($urandom_range(0, 15)), 10'($urandom_range(0, 1023)));
            end
            run_stream(30);
            n_checks++;
            if (obs_q.size() != exp_q.size())
                $display("FAIL rand%0d_count: got %0d beats, required %0d", round, obs_q.size(), exp_q.size());
            else n_pass++;
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (i >= obs_q.size())
                    $display("FAIL rand%0d_beat[%0d]: got none, required %s", round, i, ev_str(exp_q[i]));
                else if (obs_q[i] !== exp_q[i])
                    $display("FAIL rand%0d_beat[%0d]: got %s, required %s", round, i, ev_str(obs_q[i]), ev_str(exp_q[i]));
                else n_pass++;
            end
            n_checks++;
            if (err_count !== 8'(m_errs))
                $display("FAIL rand%0d_err_count: got %0d, required %0d", round, err_count, m_errs);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        apply_reset();
        drive_bits(18'b10001, 5);
        n_checks++;
        if ({valid_s2, new_block_s2, error_s2, coefficient_s2, position_s2} !== {3'b110, 10'd2, 4'd0})
            $display("FAIL stall_beat: got v=%0b nb=%0b coef=%0d pos=%0d, required v=1 nb=1 coef=2 pos=0",
                     valid_s2, new_block_s2, $signed(coefficient_s2), position_s2);
        else n_pass++;
        // Offer an EOB bit while stalled; it must not be taken.
        stall_s2 = 1'b1; bit_valid_s1 = 1'b1; bit_in_s1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge phi1); #1;
            n_checks++;
            if (bit_ready_s1 !== 1'b0) $display("FAIL stall_ready[%0d]: got %b, required 0", c, bit_ready_s1);
            else n_pass++;
            n_checks++;
            if ({valid_s2, new_block_s2, error_s2, coefficient_s2, position_s2} !== {3'b110, 10'd2, 4'd0})
                $display("FAIL stall_hold[%0d]: got v=%0b nb=%0b coef=%0d pos=%0d, required v=1 nb=1 coef=2 pos=0",
                         c, valid_s2, new_block_s2, $signed(coefficient_s2), position_s2);
            else n_pass++;
        end
        stall_s2 = 1'b0; bit_valid_s1 = 1'b0;
        @(posedge phi1); #1;
        n_checks++;
        if ({valid_s2, new_block_s2} !== 2'b00)
            $display("FAIL stall_release: got v=%0b nb=%0b, required 0 0", valid_s2, new_block_s2);
        else n_pass++;
        // Block still open at position 0: a run-0 +1 lands at position 1.
        obs_q.delete();
        put_bits(18'b110000, 6);
        run_stream(0);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== mk_ev(1, 0, 0, 10'd1, 4'd1))
            $display("FAIL stall_resume: got %0d beats first %s, required 1 beat %s", obs_q.size(),
                     (obs_q.size() > 0) ? ev_str(obs_q[0]) : "none", ev_str(mk_ev(1, 0, 0, 10'd1, 4'd1)));
        else n_pass++;
    endtask

    task automatic test_reset_mid_esc();
        apply_reset();
        drive_bits(18'b10111, 5);  // coefficient -4 at position 0
        drive_bits(18'b111000010, 9);  // ESC cut short
        reset_n = 1'b0;
        #2;
        n_checks++;
        if ({coefficient_s2, position_s2, valid_s2, new_block_s2, error_s2, err_count} !== 27'd0)
            $display("FAIL midesc_reset: got coef=%0h pos=%0h v=%0b nb=%0b err=%0b cnt=%0d, required all 0",
                     coefficient_s2, position_s2, valid_s2, new_block_s2, error_s2, err_count);
        else n_pass++;
        @(posedge phi1); #1 reset_n = 1'b1;
        obs_q.delete();
        put_bits(18'b10000, 5);
        run_stream(0);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== mk_ev(1, 1, 0, 10'd1, 4'd0))
            $display("FAIL midesc_restart: got %0d beats first %s, required 1 beat %s", obs_q.size(),
                     (obs_q.size() > 0) ? ev_str(obs_q[0]) : "none", ev_str(mk_ev(1, 1, 0, 10'd1, 4'd0)));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_plan();
        test_back_to_back();
        test_random();
        test_stall();
        test_reset_mid_esc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
